// File: rtl/dcache_pkg.sv
// Shared constants and types for the direct-mapped write-back data cache controller.
// Address layout: tag [31:10], index [9:5], word select [4:2], byte [1:0].
package dcache_pkg;

    localparam int ADDR_W   = 32;
    localparam int WORD_W   = 32;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 5;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W   = 256;

    localparam int WSEL_LSB  = 2;
    localparam int WSEL_W    = OFFSET_W - WSEL_LSB;
    localparam int INDEX_LSB = OFFSET_W;
    localparam int TAG_LSB   = OFFSET_W + INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Line storage: valid/dirty flags (cleared by reset) plus tag and data arrays
// (never reset). Combinational read at the addressed index, one write port.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int IDX_W     = INDEX_W,
    parameter int TAG_BITS  = TAG_W,
    parameter int LINE_BITS = LINE_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     index,
    input  logic                 we,
    input  logic [TAG_BITS-1:0]  wtag,
    input  logic                 wdirty,
    input  logic [LINE_BITS-1:0] wline,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_BITS-1:0]  tag,
    output logic [LINE_BITS-1:0] line
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [DEPTH];
    logic [LINE_BITS-1:0] data_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= wdirty;
        end
    end

    // NOTE: tag/data stay out of the reset domain; the cleared valid bits
    // already make their stale contents unreachable.
    always_ff @(posedge clk_i) begin
        if (we) begin
            tag_q[index]  <= wtag;
            data_q[index] <= wline;
        end
    end

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign line  = data_q[index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller: zero-latency
// hits, miss handling through WRITEBACK/ALLOCATE with a line-wide memory port.
module dcache_ctrl #(
    parameter int INDEX_W  = dcache_pkg::INDEX_W,
    parameter int OFFSET_W = dcache_pkg::OFFSET_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cpu_req_i,
    input  logic                          cpu_we_i,
    input  logic [31:0]                   cpu_addr_i,
    input  logic [31:0]                   cpu_wdata_i,
    output logic [31:0]                   cpu_rdata_o,
    output logic                          cpu_stall_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [31:0]                   mem_addr_o,
    output logic [dcache_pkg::LINE_W-1:0] mem_wdata_o,
    input  logic                          mem_ack_i,
    input  logic [dcache_pkg::LINE_W-1:0] mem_rdata_i
);

    import dcache_pkg::*;

    localparam int TAG_BITS = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SEL_W    = OFFSET_W - WSEL_LSB;

    state_t state, state_next;

    logic [TAG_BITS-1:0] cpu_tag, miss_tag, rd_tag, sram_wtag;
    logic [INDEX_W-1:0]  cpu_index, miss_index, sram_index;
    logic [SEL_W-1:0]    cpu_wsel;
    logic [LINE_W-1:0]   rd_line, sram_wline;
    logic                rd_valid, rd_dirty, sram_we, sram_wdirty;
    logic                line_hit, hit, miss;
    logic [1:0]          unused_byte;

    assign cpu_tag     = cpu_addr_i[ADDR_W-1 -: TAG_BITS];
    assign cpu_index   = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign cpu_wsel    = cpu_addr_i[OFFSET_W-1:WSEL_LSB];
    assign unused_byte = cpu_addr_i[1:0];

    // Outside IDLE the array is addressed by the captured miss, so a CPU that
    // drops or changes its request cannot redirect the fill.
    assign sram_index = (state == S_IDLE) ? cpu_index : miss_index;
    assign line_hit   = rd_valid & (rd_tag == cpu_tag);
    assign hit        = cpu_req_i & line_hit & (state == S_IDLE);
    assign miss       = cpu_req_i & ~line_hit & (state == S_IDLE);

    dcache_sram #(
        .IDX_W     (INDEX_W),
        .TAG_BITS  (TAG_BITS),
        .LINE_BITS (LINE_W)
    ) u_sram (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .index  (sram_index),
        .we     (sram_we),
        .wtag   (sram_wtag),
        .wdirty (sram_wdirty),
        .wline  (sram_wline),
        .valid  (rd_valid),
        .dirty  (rd_dirty),
        .tag    (rd_tag),
        .line   (rd_line)
    );

    // NOTE: registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            miss_tag   <= '0;
            miss_index <= '0;
        end else if (miss) begin
            miss_tag   <= cpu_tag;
            miss_index <= cpu_index;
        end
    end

    // NOTE: assigning a default first keeps the combinational blocks latch-free.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (miss) state_next = (rd_valid & rd_dirty) ? S_WRITEBACK : S_ALLOCATE;
            S_WRITEBACK: if (mem_ack_i) state_next = S_ALLOCATE;
            S_ALLOCATE:  if (mem_ack_i) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        cpu_stall_o = 1'b0;
        cpu_rdata_o = '0;
        sram_we     = 1'b0;
        sram_wtag   = cpu_tag;
        sram_wdirty = 1'b0;
        sram_wline  = rd_line;
        case (state)
            S_IDLE: begin
                cpu_stall_o = miss;
                if (hit) begin
                    cpu_rdata_o = rd_line[cpu_wsel*WORD_W +: WORD_W];
                    if (cpu_we_i) begin
                        sram_we     = 1'b1;
                        sram_wdirty = 1'b1;
                        sram_wline[cpu_wsel*WORD_W +: WORD_W] = cpu_wdata_i;
                    end
                end
            end
            S_WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {rd_tag, miss_index, {OFFSET_W{1'b0}}};
                mem_wdata_o = rd_line;
                cpu_stall_o = 1'b1;
            end
            S_ALLOCATE: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = {miss_tag, miss_index, {OFFSET_W{1'b0}}};
                cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    sram_we    = 1'b1;
                    sram_wtag  = miss_tag;
                    sram_wline = mem_rdata_i;
                end
            end
            default: ;
        endcase
        // Reset releases the pipeline at once, without waiting for an edge.
        cpu_stall_o = cpu_stall_o & rst_i;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: an array-based cache/memory model predicts
// memory transactions and load data; a monitor compares them as they occur.
module tb_dcache_ctrl;

    import dcache_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic         cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o, mem_rdata_i;

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    typedef struct { bit we; logic [31:0] addr; logic [255:0] data; } mem_txn_t;
    typedef struct { bit is_load; logic [31:0] rdata; } cpu_txn_t;

    mem_txn_t     exp_mem[$];
    cpu_txn_t     exp_cpu[$];
    int           n_cmp = 0;
    int           n_err = 0;

    logic [255:0] mem_model [logic [31:0]];
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_line  [32];

    int fixed_lat    = 3;
    bit mem_hold     = 1'b0;
    bit late_ack_req = 1'b0;
    int req_cycles   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] default_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'(w) * 32'h0101_0101) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [255:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return default_line(a);
    endfunction

    // Reference cache: direct-mapped, write-back, write-allocate, evaluated per access.
    task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input bit expect_resp);
        int           idx;
        int           w;
        logic [21:0]  tag;
        logic [31:0]  base;
        logic [31:0]  vaddr;
        idx  = int'(addr[9:5]);
        w    = int'(addr[4:2]);
        tag  = addr[31:10];
        base = {addr[31:5], 5'b0};
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                vaddr = {m_tag[idx], addr[9:5], 5'b0};
                exp_mem.push_back('{1'b1, vaddr, m_line[idx]});
                mem_model[vaddr] = m_line[idx];
            end
            exp_mem.push_back('{1'b0, base, 256'b0});
            m_line[idx]  = mem_read(base);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
        end
        if (we) begin
            m_line[idx][w*32 +: 32] = wdata;
            m_dirty[idx] = 1'b1;
        end
        if (expect_resp) exp_cpu.push_back('{!we, m_line[idx][w*32 +: 32]});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_mem.delete();
        exp_cpu.delete();
    endtask

    // Memory responder: acks after lat cycles of mem_req_o, serving model memory.
    initial begin
        int cnt;
        int lat;
        cnt = 0;
        lat = fixed_lat;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (mem_req_o) req_cycles++;
            if (late_ack_req) begin
                mem_ack_i    = 1'b1;
                mem_rdata_i  = {8{32'hBAD0_BAD0}};
                late_ack_req = 1'b0;
                cnt          = 0;
            end else if (mem_req_o && !mem_hold) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_read(mem_addr_o);
                    cnt         = 0;
                    lat         = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
                end
            end else if (!mem_req_o) begin
                cnt = 0;
                lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes something.
    always @(negedge clk_i) begin
        mem_txn_t me;
        cpu_txn_t ce;
        if (mem_req_o && mem_ack_i) begin
            if (exp_mem.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL mem_unexpected: got addr %0h we %0b expected no transaction", mem_addr_o, mem_we_o);
            end else begin
                me = exp_mem.pop_front();
                check("mem_we", 256'(mem_we_o), 256'(me.we));
                check("mem_addr", 256'(mem_addr_o), 256'(me.addr));
                if (me.we) check("mem_wdata", mem_wdata_o, me.data);
            end
        end
        if (rst_i && cpu_req_i && !cpu_stall_o) begin
            if (exp_cpu.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL cpu_unexpected: got completion at %0h expected none", cpu_addr_i);
            end else begin
                ce = exp_cpu.pop_front();
                if (ce.is_load) check("cpu_rdata", 256'(cpu_rdata_o), 256'(ce.rdata));
            end
        end
    end

    // Call at posedge+#1; returns at posedge+#1 with the request dropped.
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             output int stalls);
        bit done;
        model_access(we, addr, wdata, 1'b1);
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        stalls      = 0;
        done        = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) done = 1'b1;
            else stalls++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL access_timeout: addr %0h still stalled after %0d cycles, expected completion", addr, stalls);
        end
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
    endtask

    task automatic wait_alloc(output bit found);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk_i);
            if (mem_req_o && !mem_we_o) found = 1'b1;
        end
    endtask

    initial begin
        int           stalls;
        int           rc;
        bit           found;
        logic [255:0] l;
        logic [31:0]  addr;

        rst_i       = 1'b0;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        model_reset();
        l = default_line(32'h40);
        l[31:0] = 32'h1111_1111;
        mem_model[32'h40] = l;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_stall", 256'(cpu_stall_o), 0);
        check("rst_mem_req", 256'(mem_req_o), 0);
        check("rst_mem_we", 256'(mem_we_o), 0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_rdata", 256'(cpu_rdata_o), 0);
        check("idle_stall", 256'(cpu_stall_o), 0);

        // Cold load, fill after 3 cycles.
        do_access(1'b0, 32'h40, 32'h0, stalls);
        check("cold_miss_stalls", 256'(stalls), 4);

        // Store hit then load hit, no memory traffic.
        rc = req_cycles;
        do_access(1'b1, 32'h44, 32'hDEAD_BEEF, stalls);
        check("store_hit_stalls", 256'(stalls), 0);
        do_access(1'b0, 32'h44, 32'h0, stalls);
        check("load_hit_stalls", 256'(stalls), 0);
        check("hit_mem_req_cycles", 256'(req_cycles - rc), 0);

        // Conflict miss evicts the dirty line.
        do_access(1'b0, 32'h440, 32'h0, stalls);
        check("writeback_miss_stalls", 256'(stalls), 7);

        // Reset in the middle of ALLOCATE, followed by a stray ack.
        mem_hold    = 1'b1;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h40;
        cpu_req_i   = 1'b1;
        wait_alloc(found);
        check("reach_alloc_before_reset", 256'(found), 1);
        rst_i = 1'b0;
        #1;
        check("reset_mem_req", 256'(mem_req_o), 0);
        check("reset_mem_we", 256'(mem_we_o), 0);
        check("reset_stall", 256'(cpu_stall_o), 0);
        cpu_req_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i        = 1'b1;
        mem_hold     = 1'b0;
        late_ack_req = 1'b1;
        @(negedge clk_i);
        check("late_ack_req_low", 256'(mem_req_o), 0);
        @(posedge clk_i);
        #1;
        check("late_ack_ignored", 256'(mem_req_o), 0);
        do_access(1'b0, 32'h40, 32'h0, stalls);
        check("reload_after_reset_stalls", 256'(stalls), 4);

        // Request dropped during ALLOCATE: the fill must still land.
        model_access(1'b0, 32'h1840, 32'h0, 1'b0);
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h1840;
        cpu_req_i  = 1'b1;
        wait_alloc(found);
        check("reach_alloc_before_drop", 256'(found), 1);
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk_i);
            if (!mem_req_o) found = 1'b1;
        end
        check("dropped_fill_completes", 256'(found), 1);
        @(posedge clk_i);
        #1;
        do_access(1'b0, 32'h1840, 32'h0, stalls);
        check("dropped_fill_hit_stalls", 256'(stalls), 0);

        // Same index, alternating tags.
        do_access(1'b1, 32'h2044, 32'hCAFE_F00D, stalls);
        check("conflict_store_stalls", 256'(stalls), 4);
        do_access(1'b0, 32'h40, 32'h0, stalls);
        check("conflict_evict_stalls", 256'(stalls), 7);
        do_access(1'b0, 32'h2044, 32'h0, stalls);
        check("conflict_reload_stalls", 256'(stalls), 4);

        // Random traffic over few indices and tags to force evictions.
        fixed_lat = 0;
        for (int i = 0; i < 400; i++) begin
            addr = {22'($urandom_range(0, 2)), 5'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            do_access(1'($urandom_range(0, 1)), addr, $urandom, stalls);
        end

        repeat (5) @(posedge clk_i);
        check("exp_mem_drained", 256'(exp_mem.size()), 0);
        check("exp_cpu_drained", 256'(exp_cpu.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter INDEX_W, default 5, sets the line-index width, giving 32 lines.
REQ-002 Parameter OFFSET_W, default 5, sets the byte-offset width, giving 32-byte (256-bit) lines.
REQ-003 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 cpu_req_i  in  1  CPU data-memory access valid (load or store).
REQ-006 cpu_we_i  in  1  1 = store, 0 = load.
REQ-007 cpu_addr_i  in  32  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata_i  in  32  store data.
REQ-009 cpu_rdata_o  out  32  load data.
REQ-010 cpu_stall_o  out  1  pipeline freeze; CPU holds all cpu_* inputs stable while it is high.
REQ-011 mem_req_o  out  1  main-memory request, held until acknowledged.
REQ-012 mem_we_o  out  1  1 = line writeback, 0 = line fill.
REQ-013 mem_addr_o  out  32  line-aligned address, low OFFSET_W bits zero.
REQ-014 mem_wdata_o  out  256  writeback line.
REQ-015 mem_ack_i  in  1  one-cycle completion pulse; fill data is valid in the same cycle.
REQ-016 mem_rdata_i  in  256  fill line.

Function
REQ-017 Address split SHALL be: tag = [31:10] (22 bits), index = [9:5], word select = [4:2].
REQ-018 Cache organisation SHALL be direct-mapped, write-back, write-allocate; each line holds valid, dirty, tag and 256 data bits.
REQ-019 Hit SHALL be defined as cpu_req_i & valid[index] & (tag match) while in IDLE.
REQ-020 Load hit SHALL have zero latency: cpu_rdata_o is driven combinationally with the selected word and cpu_stall_o = 0.
REQ-021 Store hit SHALL write the selected word at the next edge and set dirty; cpu_stall_o = 0.
REQ-022 Miss SHALL raise cpu_stall_o combinationally in the same cycle; cpu_stall_o stays high until the state returns to IDLE and the access hits.
REQ-023 FSM states SHALL be IDLE, WRITEBACK and ALLOCATE.
REQ-024 IDLE transitions on a miss: go to WRITEBACK if the victim line is valid & dirty, otherwise go to ALLOCATE.
REQ-025 In WRITEBACK: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = victim line; on mem_ack_i go to ALLOCATE.
REQ-026 In ALLOCATE: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {cpu tag, index, 5'b0}.
REQ-027 On mem_ack_i in ALLOCATE: write mem_rdata_i into the line, set valid = 1, dirty = 0, update the tag, and go to IDLE.
REQ-028 After a fill, the access SHALL complete as a hit in the first IDLE cycle, so minimum miss penalty = memory latency + 1 cycle.
REQ-029 mem_req_o SHALL deassert in the cycle after mem_ack_i and SHALL never be high in IDLE.
REQ-030 mem_ack_i SHALL be ignored when mem_req_o = 0.
REQ-031 If cpu_req_i drops mid-miss, the outstanding memory transaction SHALL still complete and the line SHALL still be installed.
REQ-032 When cpu_req_i = 0: cpu_stall_o = 0 in IDLE and cpu_rdata_o = 0.
REQ-033 Back-to-back accesses to the same index with different tags SHALL each miss and each evict the previous line.

Reset
REQ-034 Asserting rst_i low, at any time including mid-transaction, SHALL immediately force: state = IDLE, all valid and dirty bits = 0, mem_req_o = 0, mem_we_o = 0, cpu_stall_o = 0.
REQ-035 Tag and data arrays SHALL NOT be cleared on reset.
REQ-036 A memory transaction interrupted by reset SHALL be abandoned, and a late mem_ack_i SHALL be ignored.

Structure
REQ-037 Package dcache_pkg SHALL hold the FSM state enum, TAG_W/INDEX_W/OFFSET_W, the LINE_W = 256 constant, and field-slice helper constants.
REQ-038 Tag, valid, dirty and data storage SHALL live in one sub-module, dcache_sram, with write-enable, index, tag/flags and line ports; FSM and hit logic stay in dcache_ctrl.

Verification
REQ-039 Cold load 0x0000_0040 with memory returning the line with word0 = 0x1111_1111 after 3 cycles -> ALLOCATE with mem_addr_o = 0x40, stall for 4 cycles, then cpu_rdata_o = 0x1111_1111 with stall 0.
REQ-040 Store 0xDEAD_BEEF to 0x44 after the fill -> no stall; a following load of 0x44 returns 0xDEAD_BEEF; no mem_req_o.
REQ-041 Load 0x0000_0440 (same index, new tag) -> WRITEBACK with mem_addr_o = 0x40 and mem_wdata_o word1 = 0xDEAD_BEEF, then ALLOCATE with mem_addr_o = 0x440.
REQ-042 rst_i pulsed low during ALLOCATE, with a late mem_ack_i afterwards -> mem_req_o = 0 immediately; the ack is ignored; a reload of 0x40 misses.
REQ-043 cpu_req_i dropped during ALLOCATE -> the fill still installs; a later load of the same address hits with no stall.
